// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan driver.
// lz_mask works on a fixed maximum width so one function serves any digit count.
package seg_pkg;

    localparam int MAX_NDIG = 16;
    localparam int MAX_IDXW = 4;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    localparam logic [MAX_NDIG-1:0] DIG_OFF = '1;

    // Bit i set means digit i and every more significant digit are zero; bit 0 never set.
    function automatic logic [MAX_NDIG-1:0] lz_mask(
        input logic [4*MAX_NDIG-1:0] disp,
        input int                    ndig
    );
        logic [MAX_NDIG-1:0] mask;
        logic                zero_run;
        mask     = '0;
        zero_run = 1'b1;
        for (int i = MAX_NDIG - 1; i >= 0; i--) begin
            if (i < ndig) begin
                zero_run = zero_run & (disp[4*i +: 4] == 4'd0);
                if (i >= 1) begin
                    mask[i] = zero_run;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Data/control bundle between the value source and the scan driver.
// The slave side is the driver; the master side is whoever supplies values.
interface seg_scan_mux_if #(
    parameter int NDIG = 4
) ();
    import seg_pkg::*;

    logic [4*NDIG-1:0] din;
    logic              load;
    logic              lz_en;
    logic [3:0]        num;
    logic [NDIG-1:0]   dig_n;
    logic              frame;
    logic              upd_done;

    modport master (
        output din, load, lz_en,
        input  num, dig_n, frame, upd_done
    );

    modport slave (
        input  din, load, lz_en,
        output num, dig_n, frame, upd_done
    );

endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scan driver: blanked digit slots,
// frame-aligned value updates with a load bypass, optional leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);

    localparam int IDXW = $clog2(NDIG);
    localparam int CNTW = $clog2(DIV);
    localparam logic [IDXW-1:0] IDX_LAST      = IDXW'(NDIG - 1);
    localparam logic [CNTW-1:0] CNT_BLANK_END = CNTW'(BLANK - 1);
    localparam logic [CNTW-1:0] CNT_ON_END    = CNTW'(DIV - BLANK - 1);

    if (NDIG < 2 || NDIG > MAX_NDIG || BLANK < 1 || DIV < BLANK + 1) begin : g_bad_params
        $error("seg_scan_mux: illegal NDIG/DIV/BLANK combination");
    end

    state_t             r_st, w_st_next;
    logic [CNTW-1:0]    r_cnt, w_cnt_next;
    logic [IDXW-1:0]    r_idx, w_idx_next;
    logic [4*NDIG-1:0]  r_shadow, w_shadow_next;
    logic [4*NDIG-1:0]  r_disp, w_disp_next;
    logic               r_pend, w_pend_next;
    logic [3:0]         r_num, w_num_next;
    logic [NDIG-1:0]    r_dig_n, w_dig_n_next;
    logic               r_frame, w_frame_next;
    logic               r_upd_done, w_upd_done_next;

    logic               w_end_blank;
    logic               w_end_on;
    logic               w_boundary;
    logic [3:0]         w_digit [NDIG];
    logic [NDIG-1:0]    w_sel_n;
    logic [4*MAX_NDIG-1:0] w_disp_wide;
    logic [MAX_NDIG-1:0]   w_mask;

    // Digits of the post-boundary value, so num picks up a bypassed load immediately.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        assign w_digit[gi] = w_disp_next[4*gi +: 4];
        assign w_sel_n[gi] = (r_idx != IDXW'(gi));
    end

    always_comb begin
        w_disp_wide             = '0;
        w_disp_wide[4*NDIG-1:0] = r_disp;
    end

    assign w_mask = lz_mask(w_disp_wide, NDIG);

    always_comb begin
        w_st_next   = r_st;
        w_cnt_next  = r_cnt + 1'b1;
        w_idx_next  = r_idx;
        w_end_blank = 1'b0;
        w_end_on    = 1'b0;
        case (r_st)
            S_BLANK: begin
                if (r_cnt == CNT_BLANK_END) begin
                    w_st_next   = S_ON;
                    w_cnt_next  = '0;
                    w_end_blank = 1'b1;
                end
            end
            S_ON: begin
                if (r_cnt == CNT_ON_END) begin
                    w_st_next  = S_BLANK;
                    w_cnt_next = '0;
                    w_end_on   = 1'b1;
                    w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_st_next  = S_BLANK;
                w_cnt_next = '0;
            end
        endcase
    end

    assign w_boundary = w_end_on && (r_idx == IDX_LAST);

    always_comb begin
        w_shadow_next   = bus.load ? bus.din : r_shadow;
        w_pend_next     = r_pend;
        w_disp_next     = r_disp;
        w_upd_done_next = 1'b0;
        if (w_boundary) begin
            // A load landing on the boundary cycle goes straight to the display.
            if (bus.load) begin
                w_disp_next     = bus.din;
                w_pend_next     = 1'b0;
                w_upd_done_next = 1'b1;
            end else if (r_pend) begin
                w_disp_next     = r_shadow;
                w_pend_next     = 1'b0;
                w_upd_done_next = 1'b1;
            end
        end else if (bus.load) begin
            w_pend_next = 1'b1;
        end
        w_frame_next = w_boundary;
        w_num_next   = w_end_on ? w_digit[w_idx_next] : r_num;

        w_dig_n_next = r_dig_n;
        if (w_end_blank) begin
            w_dig_n_next = (bus.lz_en && w_mask[MAX_IDXW'(r_idx)]) ? DIG_OFF[NDIG-1:0] : w_sel_n;
        end else if (w_end_on) begin
            w_dig_n_next = DIG_OFF[NDIG-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st       <= S_BLANK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            r_disp     <= '0;
            r_pend     <= 1'b0;
            r_num      <= 4'd0;
            r_dig_n    <= DIG_OFF[NDIG-1:0];
            r_frame    <= 1'b0;
            r_upd_done <= 1'b0;
        end else begin
            r_st       <= w_st_next;
            r_cnt      <= w_cnt_next;
            r_idx      <= w_idx_next;
            r_shadow   <= w_shadow_next;
            r_disp     <= w_disp_next;
            r_pend     <= w_pend_next;
            r_num      <= w_num_next;
            r_dig_n    <= w_dig_n_next;
            r_frame    <= w_frame_next;
            r_upd_done <= w_upd_done_next;
        end
    end

    assign bus.num      = r_num;
    assign bus.dig_n    = r_dig_n;
    assign bus.frame    = r_frame;
    assign bus.upd_done = r_upd_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux; expected outputs come from a timeline
// model (cycle count since reset plus a log of loads), not from the RTL structure.
module tb_seg_scan_mux;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int P     = NDIG * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_mux_if #(.NDIG(NDIG)) bus ();

    seg_scan_mux #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] v;
    } load_t;

    load_t loads[$];
    int    t = 0;
    bit    lz_slot = 1'b0;
    int    errors = 0;
    int    checks = 0;

    // Value shown during frame f: the most recent load issued no later than the cycle before f.
    function automatic logic [15:0] frame_val(int f);
        logic [15:0] v = 16'h0000;
        foreach (loads[i]) if (loads[i].t <= f * P - 1) v = loads[i].v;
        return v;
    endfunction

    function automatic bit frame_upd(int f);
        if (f < 1) return 1'b0;
        foreach (loads[i]) if (loads[i].t >= (f - 1) * P && loads[i].t <= f * P - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] digit(logic [15:0] v, int s);
        return v[4*s +: 4];
    endfunction

    function automatic bit suppressed(logic [15:0] v, int s);
        return (s != 0) && ((v >> (4 * s)) == 16'd0);
    endfunction

    function automatic logic [3:0] exp_dig_n();
        int          s = (t / DIV) % NDIG;
        logic [15:0] v = frame_val(t / P);
        if (t % DIV < BLANK) return 4'hF;
        if (lz_slot && suppressed(v, s)) return 4'hF;
        return ~(4'b0001 << s);
    endfunction

    function automatic logic [3:0] exp_num();
        return digit(frame_val(t / P), (t / DIV) % NDIG);
    endfunction

    function automatic logic exp_frame();
        return (t > 0) && (t % P == 0);
    endfunction

    function automatic logic exp_upd();
        return exp_frame() && frame_upd(t / P);
    endfunction

    // Drive one cycle of inputs, advance the clock, update the timeline; ends just after negedge.
    task automatic cycle(input logic ld, input logic [15:0] d);
        load_t e;
        bus.load = ld;
        bus.din  = d;
        if (rst_n && ld) begin
            e.t = t;
            e.v = d;
            loads.push_back(e);
            $display("load t=%0d din=%h lz_en=%0b", t, d, bus.lz_en);
        end
        if (rst_n && (t % DIV == BLANK - 1)) lz_slot = bus.lz_en;
        @(posedge clk);
        if (rst_n) t++;
        else begin
            t = 0;
            loads.delete();
        end
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic run_to(input int phase);
        while (t % P != phase) cycle(1'b0, bus.din);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b1, 16'h4321);
        cycle(1'b0, 16'h0000);
        checks++; if (bus.dig_n !== 4'hF) begin errors++; $display("FAIL reset_dig_n got=%b want=1111", bus.dig_n); end
        checks++; if (bus.num !== 4'd0) begin errors++; $display("FAIL reset_num got=%0d want=0", bus.num); end
        checks++; if (bus.frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b want=0", bus.frame); end
        checks++; if (bus.upd_done !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b want=0", bus.upd_done); end
        rst_n = 1'b1;
        for (int k = 0; k < BLANK; k++) begin
            cycle(1'b0, 16'h0000);
            if (k < BLANK - 1) begin
                checks++; if (bus.dig_n !== 4'hF) begin errors++; $display("FAIL release_dark got=%b want=1111", bus.dig_n); end
            end
        end
        checks++; if (bus.dig_n !== 4'b1110) begin errors++; $display("FAIL release_dig0 got=%b want=1110", bus.dig_n); end
        checks++; if (bus.num !== 4'd0) begin errors++; $display("FAIL release_num got=%0d want=0", bus.num); end
    endtask

    task automatic test_basic_scan();
        logic [3:0] seq [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        int f0 = t / P;
        bus.lz_en = 1'b0;
        cycle(1'b1, 16'h1234);
        while (t < (f0 + 3) * P) begin
            cycle(1'b0, 16'h0000);
            checks++; if (bus.dig_n !== exp_dig_n()) begin errors++; $display("FAIL basic_dig_n t=%0d got=%b want=%b", t, bus.dig_n, exp_dig_n()); end
            checks++; if (bus.num !== exp_num()) begin errors++; $display("FAIL basic_num t=%0d got=%0d want=%0d", t, bus.num, exp_num()); end
            checks++; if (bus.frame !== exp_frame()) begin errors++; $display("FAIL basic_frame t=%0d got=%b want=%b", t, bus.frame, exp_frame()); end
            checks++; if (bus.upd_done !== exp_upd()) begin errors++; $display("FAIL basic_upd t=%0d got=%b want=%b", t, bus.upd_done, exp_upd()); end
            if (t / P == f0 + 1 && t % DIV == BLANK) begin
                checks++; if (bus.num !== seq[(t / DIV) % NDIG]) begin errors++; $display("FAIL basic_seq t=%0d got=%0d want=%0d", t, bus.num, seq[(t / DIV) % NDIG]); end
            end
        end
    endtask

    task automatic test_lz();
        int f0 = t / P;
        int bad = 0;
        bus.lz_en = 1'b1;
        cycle(1'b1, 16'h0007);
        while (t < (f0 + 3) * P) begin
            cycle(1'b0, 16'h0000);
            checks++; if (bus.dig_n !== exp_dig_n()) begin errors++; $display("FAIL lz_dig_n t=%0d got=%b want=%b", t, bus.dig_n, exp_dig_n()); end
            if (t / P >= f0 + 1 && bus.dig_n[3:1] !== 3'b111) bad++;
            if (t / P >= f0 + 1 && t % P == BLANK) begin
                checks++; if (bus.num !== 4'd7 || bus.dig_n !== 4'b1110) begin errors++; $display("FAIL lz_slot0 t=%0d got num=%0d dig_n=%b want num=7 dig_n=1110", t, bus.num, bus.dig_n); end
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL lz_upper_lit got=%0d cycles want=0", bad); end
    endtask

    task automatic test_codes();
        int f0 = t / P;
        bus.lz_en = 1'b1;
        cycle(1'b1, 16'h00A0);
        while (t < (f0 + 3) * P) begin
            cycle(1'b0, 16'h0000);
            checks++; if (bus.dig_n !== exp_dig_n()) begin errors++; $display("FAIL codes_dig_n t=%0d got=%b want=%b", t, bus.dig_n, exp_dig_n()); end
            checks++; if (bus.num !== exp_num()) begin errors++; $display("FAIL codes_num t=%0d got=%0d want=%0d", t, bus.num, exp_num()); end
            if (t / P == f0 + 1 && t % P == DIV + BLANK) begin
                checks++; if (bus.dig_n !== 4'b1101 || bus.num !== 4'hA) begin errors++; $display("FAIL codes_slot1 got dig_n=%b num=%0d want 1101/10", bus.dig_n, bus.num); end
            end
            if (t / P == f0 + 1 && (t % P == 2 * DIV + BLANK || t % P == 3 * DIV + BLANK)) begin
                checks++; if (bus.dig_n !== 4'hF) begin errors++; $display("FAIL codes_dark t=%0d got=%b want=1111", t, bus.dig_n); end
            end
        end
    endtask

    task automatic test_multi_load();
        int f0;
        int ups = 0;
        int ones = 0;
        bus.lz_en = 1'b0;
        run_to(10);
        f0 = t / P;
        cycle(1'b1, 16'h1111);
        cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);
        cycle(1'b1, 16'h2222);
        while (t < (f0 + 3) * P) begin
            cycle(1'b0, 16'h0000);
            checks++; if (bus.num !== exp_num()) begin errors++; $display("FAIL multi_num t=%0d got=%0d want=%0d", t, bus.num, exp_num()); end
            checks++; if (bus.dig_n !== exp_dig_n()) begin errors++; $display("FAIL multi_dig_n t=%0d got=%b want=%b", t, bus.dig_n, exp_dig_n()); end
            if (bus.upd_done === 1'b1) ups++;
            if (bus.num === 4'd1) ones++;
        end
        checks++; if (ups != 1) begin errors++; $display("FAIL multi_upd_count got=%0d want=1", ups); end
        checks++; if (ones != 0) begin errors++; $display("FAIL multi_stale_value got=%0d cycles showing 1 want=0", ones); end
    endtask

    task automatic test_load_boundary();
        run_to(P - 1);
        cycle(1'b1, 16'h5678);
        checks++; if (bus.frame !== 1'b1 || bus.upd_done !== 1'b1) begin errors++; $display("FAIL bypass_pulses got frame=%b upd=%b want 1/1", bus.frame, bus.upd_done); end
        checks++; if (bus.num !== 4'd8) begin errors++; $display("FAIL bypass_num got=%0d want=8", bus.num); end
        for (int k = 0; k < BLANK; k++) cycle(1'b0, 16'h0000);
        checks++; if (bus.dig_n !== 4'b1110 || bus.num !== 4'd8) begin errors++; $display("FAIL bypass_lit got dig_n=%b num=%0d want 1110/8", bus.dig_n, bus.num); end
    endtask

    task automatic test_random();
        int          t_end = t + 5 * P;
        logic [15:0] d;
        logic        ld;
        while (t < t_end) begin
            ld = ($urandom_range(0, 11) == 0);
            d  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            if (t % 7 == 0) bus.lz_en = 1'($urandom_range(0, 1));
            cycle(ld, d);
            checks++; if (bus.dig_n !== exp_dig_n()) begin errors++; $display("FAIL rand_dig_n t=%0d got=%b want=%b", t, bus.dig_n, exp_dig_n()); end
            checks++; if (bus.num !== exp_num()) begin errors++; $display("FAIL rand_num t=%0d got=%0d want=%0d", t, bus.num, exp_num()); end
            checks++; if (bus.frame !== exp_frame()) begin errors++; $display("FAIL rand_frame t=%0d got=%b want=%b", t, bus.frame, exp_frame()); end
            checks++; if (bus.upd_done !== exp_upd()) begin errors++; $display("FAIL rand_upd t=%0d got=%b want=%b", t, bus.upd_done, exp_upd()); end
        end
    endtask

    task automatic test_reset_mid();
        bus.lz_en = 1'b0;
        cycle(1'b1, 16'h1234);
        run_to(0);
        run_to(2 * DIV + BLANK + 1);
        cycle(1'b1, 16'h9999);
        checks++; if (bus.dig_n !== 4'b1011 || bus.num !== 4'd2) begin errors++; $display("FAIL mid_pre got dig_n=%b num=%0d want 1011/2", bus.dig_n, bus.num); end
        rst_n = 1'b0;
        cycle(1'b0, 16'h0000);
        checks++; if (bus.dig_n !== 4'hF || bus.num !== 4'd0) begin errors++; $display("FAIL mid_reset got dig_n=%b num=%0d want 1111/0", bus.dig_n, bus.num); end
        checks++; if (bus.frame !== 1'b0 || bus.upd_done !== 1'b0) begin errors++; $display("FAIL mid_pulses got frame=%b upd=%b want 0/0", bus.frame, bus.upd_done); end
        rst_n = 1'b1;
        while (t < 2 * P + 4) begin
            cycle(1'b0, 16'h0000);
            checks++; if (bus.num !== 4'd0) begin errors++; $display("FAIL mid_after_num t=%0d got=%0d want=0", t, bus.num); end
            checks++; if (bus.dig_n !== exp_dig_n()) begin errors++; $display("FAIL mid_after_dig_n t=%0d got=%b want=%b", t, bus.dig_n, exp_dig_n()); end
            checks++; if (bus.upd_done !== 1'b0) begin errors++; $display("FAIL mid_after_upd t=%0d got=%b want=0", t, bus.upd_done); end
        end
    endtask

    initial begin
        bus.din   = 16'h0000;
        bus.load  = 1'b0;
        bus.lz_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_scan();
        test_lz();
        test_codes();
        test_multi_load();
        test_load_boundary();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scan driver for a common-anode, multi-digit 7-segment display. It sits directly upstream of the 7-segment decoder: it latches a packed BCD value, walks the digits one at a time, and presents the active digit's 4-bit code on `num` (the decoder's input) together with an active-low digit-enable bus. A blanking interval is inserted before each digit to prevent ghosting. New values are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NDIG`, default 4: number of digits; must be ≥ 2.
- `DIV`, default 50000: clock cycles per digit slot; must be ≥ BLANK+1.
- `BLANK`, default 500: cycles at the start of each slot with every digit off; must be ≥ 1.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, **synchronous, active-low**.
- `din` in 4*NDIG: packed BCD value; `din[3:0]` is the least significant (rightmost) digit.
- `load` in 1: one-cycle write strobe for `din`.
- `lz_en` in 1: leading-zero suppression enable, sampled every cycle.
- `num` out 4: code of the current digit, driven to the decoder.
- `dig_n` out NDIG: digit enables, active-low, at most one low at a time; bit 0 is the rightmost digit.
- `frame` out 1: one-cycle pulse at the start of each frame.
- `upd_done` out 1: one-cycle pulse when a pending value becomes the displayed value.

## Operation
- **Registers:**
  - `shadow`: holds the last loaded value.
  - `pend`: flag set when `shadow` holds a value not yet displayed.
  - `disp`: the displayed value.
  - `idx`: current digit index.
  - `cnt`: slot cycle counter.
  - `st`: FSM state.
- **FSM, two states, one slot per digit:**
  - **S_BLANK:** `dig_n` is all ones. After BLANK cycles (`cnt` = BLANK-1), go to S_ON.
  - **S_ON:** `dig_n[idx]` is 0 unless the digit is suppressed. After DIV-BLANK cycles, go to S_BLANK.
  - Leaving S_ON: `idx` increments, wrapping from NDIG-1 to 0.
  - `cnt` resets to 0 on every state change.
- **Frame boundary:** the final cycle of S_ON while `idx` = NDIG-1.
  - If `pend`=1: `disp` ← `shadow` and `pend` ← 0.
- **Load:** `load`=1 sets `shadow` ← `din` and `pend` ← 1.
  - Repeated loads within one frame: the last one wins.
- **Load and frame boundary in the same cycle:** `disp` ← `din` directly (bypass), and `pend` ← 0.
- **`num`:** registered.
  - Updated only on the S_ON→S_BLANK edge, to the new `idx`'s digit taken from the post-boundary `disp`.
  - Therefore `num` never changes while a digit is lit.
- **Leading-zero suppression**, when `lz_en`=1:
  - Digit `i` (i ≥ 1) is suppressed when digit `i` and every more significant digit equal 0.
  - A suppressed digit keeps `dig_n` all ones for its whole S_ON phase.
  - Digit 0 is never suppressed.
  - Codes 10–15 count as non-zero. They pass through unchanged, and the decoder shows them as a dash.
- **`frame`:** high for the first cycle of digit 0's S_BLANK.
- **`upd_done`:** high in the same cycle as `frame`, only if a transfer happened at the boundary just before it.

## Timing
- **Reset values:** `num`=0, `dig_n`=all ones, `frame`=0, `upd_done`=0. Internally: `shadow`=0, `disp`=0, `pend`=0, `idx`=0, `cnt`=0, `st`=S_BLANK.
- **Reset mid-operation:** the outputs above take effect on the first clock edge with `rst_n`=0. A pending load is discarded.
- **After reset release:** BLANK cycles dark, then digit 0 lit with `num`=0.
- **Frame period:** NDIG*DIV cycles.
- **Load-to-display latency:** the value is displayed from the next frame start. Worst case is NDIG*DIV cycles, best case 1 cycle (the bypass case).
- **`dig_n` and `num`:** both registered, with no combinational path from inputs.
- **`lz_en`:** takes effect at the next S_ON entry.

## Structure
- **Package `seg_pkg`:**
  - State enum `{S_BLANK, S_ON}`.
  - `DIG_OFF` (all-ones) constant.
  - A function `lz_mask(disp)` returning the per-digit suppression vector.
- **No sub-module:** the counter, FSM and latches are small enough to live in one module.

## Test plan
All scenarios use NDIG=4, DIV=8, BLANK=2.
1. **Basic scan:** reset, then load `din`=16'h1234.
   - From the next frame, `num` sequence is 4,3,2,1.
   - `dig_n` sequence is 1110, 1101, 1011, 0111, each low for 6 cycles, separated by 2 cycles of 1111.
   - `upd_done` and `frame` are coincident.
2. **Leading-zero suppression:** `lz_en`=1, `din`=16'h0007.
   - Only `dig_n[0]` ever goes low, and `num`=7 in slot 0.
   - Slots 1–3 stay at 1111.
3. **Codes above 9:** `lz_en`=1, `din`=16'h00A0.
   - Digit 0 is lit with `num`=0; digit 1 is lit with `num`=10.
   - Digits 2–3 stay dark.
4. **Multiple loads in one frame:** load 16'h1111 mid-frame, then 16'h2222 three cycles later.
   - Only 2222 is displayed; 1111 never appears.
   - `upd_done` pulses exactly once.
5. **Load at frame boundary:** assert `load` with 16'h5678 on the frame-boundary cycle.
   - The next cycle has `frame`=`upd_done`=1, and digit 0 shows `num`=8.
6. **Reset mid-operation:** drop `rst_n` during digit 2's S_ON with `disp`=16'h1234.
   - Next cycle: `dig_n`=1111, `num`=0, no pulses.
   - After release, the display shows 0000.
